result_display_driver: RTL and testbench

//  Downstream stage of the calculator datapath. Takes the 10-bit operation result,

---
 rtl/result_display_driver.sv | 194 +++++++++++++++++++
 tb/tb_result_display_driver.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/result_display_driver.sv
// result_display_driver
//   Converts a 10-bit calculator result (unsigned, or two's complement when
//   signed_mode is set) to BCD with a sequential double-dabble engine. It then
//   drives a 4-digit multiplexed, active-low seven-segment display with optional
//   leading-zero blanking. A result that arrives while a conversion is running
//   is held in a one-deep pending buffer; a newer arrival replaces it.
// Parameters
//   REFRESH_DIV  clock cycles each digit stays lit before the scan advances (>=2)
//   LZ_BLANK     1 = dark leading zeros, 0 = always show all four digits
// Ports
//   clock        system clock, posedge
//   reset        synchronous, active-high
//   value_in     result word
//   value_valid  single-cycle strobe qualifying value_in / signed_mode
//   signed_mode  1 = value_in is two's complement
//   blank        1 = all digits dark, scan keeps running
//   busy         conversion in progress
//   seg          {g,f,e,d,c,b,a}, active-low, registered
//   an           digit enables, active-low one-hot, an[0] = rightmost digit
//   dp           decimal point, active-low, always off
module result_display_driver #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter bit          LZ_BLANK    = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] value_in,
    input  logic       value_valid,
    input  logic       signed_mode,
    input  logic       blank,
    output logic       busy,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

    state_t           state, state_next;
    logic [3:0]       iter;
    logic [9:0]       mag;
    logic [15:0]      bcd, bcd_adj;
    logic             conv_neg;
    logic             pend_valid, pend_signed;
    logic [9:0]       pend_value;
    logic [15:0]      disp_bcd;
    logic             disp_neg;
    logic [CNT_W-1:0] scan_cnt;
    logic [1:0]       idx;

    logic             cap_go, cap_signed, cap_neg;
    logic [9:0]       cap_value, cap_mag;
    logic [3:0]       nib;
    logic             upper_zero;
    logic [6:0]       glyph;

    function automatic logic [6:0] seven_seg(input logic [3:0] d);
        case (d)
            4'd0:    seven_seg = 7'h40;
            4'd1:    seven_seg = 7'h79;
            4'd2:    seven_seg = 7'h24;
            4'd3:    seven_seg = 7'h30;
            4'd4:    seven_seg = 7'h19;
            4'd5:    seven_seg = 7'h12;
            4'd6:    seven_seg = 7'h02;
            4'd7:    seven_seg = 7'h78;
            4'd8:    seven_seg = 7'h00;
            4'd9:    seven_seg = 7'h10;
            default: seven_seg = 7'h7F;
        endcase
    endfunction

    // A fresh strobe in IDLE wins over a held pending value.
    always_comb begin
        cap_go     = 1'b0;
        cap_value  = value_in;
        cap_signed = signed_mode;
        if (state == IDLE) begin
            if (value_valid) begin
                cap_go = 1'b1;
            end else if (pend_valid) begin
                cap_go     = 1'b1;
                cap_value  = pend_value;
                cap_signed = pend_signed;
            end
        end
        cap_neg = cap_signed & cap_value[9];
        cap_mag = cap_neg ? (~cap_value + 10'd1) : cap_value;
    end

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3
                                                         : bcd[4*i +: 4];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cap_go) state_next = SHIFT;
            SHIFT:   if (iter == 4'd9) state_next = UPDATE;
            UPDATE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign dp   = 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            iter        <= '0;
            mag         <= '0;
            bcd         <= '0;
            conv_neg    <= 1'b0;
            pend_valid  <= 1'b0;
            pend_value  <= '0;
            pend_signed <= 1'b0;
            disp_bcd    <= '0;
            disp_neg    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cap_go) begin
                        mag        <= cap_mag;
                        conv_neg   <= cap_neg;
                        bcd        <= '0;
                        iter       <= '0;
                        pend_valid <= 1'b0;
                    end
                end
                SHIFT: begin
                    {bcd, mag} <= {bcd_adj[14:0], mag, 1'b0};
                    iter       <= iter + 4'd1;
                end
                UPDATE: begin
                    disp_bcd <= bcd;
                    disp_neg <= conv_neg;
                end
                default: ;
            endcase
            if (state != IDLE && value_valid) begin
                pend_valid  <= 1'b1;
                pend_value  <= value_in;
                pend_signed <= signed_mode;
            end
        end
    end

    // Digit for the current scan position; a digit is a leading zero when it
    // and every digit above it are zero.
    always_comb begin
        nib        = disp_bcd[{idx, 2'b00} +: 4];
        upper_zero = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (i >= 32'(idx) && disp_bcd[4*i +: 4] != 4'd0) upper_zero = 1'b0;
        end
        if (disp_neg && idx == 2'd3)                    glyph = 7'h3F;
        else if (LZ_BLANK && idx != 2'd0 && upper_zero) glyph = 7'h7F;
        else                                            glyph = seven_seg(nib);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            scan_cnt <= '0;
            idx      <= '0;
            seg      <= 7'h7F;
            an       <= 4'hF;
        end else begin
            if (scan_cnt == CNT_W'(REFRESH_DIV - 1)) begin
                scan_cnt <= '0;
                idx      <= idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + CNT_W'(1);
            end
            if (blank) begin
                seg <= 7'h7F;
                an  <= 4'hF;
            end else begin
                seg <= glyph;
                an  <= ~(4'b0001 << idx);
            end
        end
    end

endmodule

// File: tb/tb_result_display_driver.sv
// Bench for result_display_driver. Two instances share all inputs, one with
// leading-zero blanking and one without. A transaction-level model (decimal
// arithmetic, a countdown for conversion time, a pending slot) predicts busy,
// seg, an and dp every cycle; directed tests add literal glyph expectations.
module tb_result_display_driver;

    localparam int DIV = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] value_in = '0;
    logic       value_valid = 1'b0;
    logic       signed_mode = 1'b0;
    logic       blank = 1'b0;

    logic       busy_a, dp_a, busy_b, dp_b;
    logic [6:0] seg_a, seg_b;
    logic [3:0] an_a, an_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    result_display_driver #(.REFRESH_DIV(DIV), .LZ_BLANK(1'b1)) dut_lz (
        .clock(clock), .reset(reset), .value_in(value_in), .value_valid(value_valid),
        .signed_mode(signed_mode), .blank(blank),
        .busy(busy_a), .seg(seg_a), .an(an_a), .dp(dp_a)
    );

    result_display_driver #(.REFRESH_DIV(DIV), .LZ_BLANK(1'b0)) dut_nolz (
        .clock(clock), .reset(reset), .value_in(value_in), .value_valid(value_valid),
        .signed_mode(signed_mode), .blank(blank),
        .busy(busy_b), .seg(seg_b), .an(an_b), .dp(dp_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    function automatic logic [6:0] glyph_of(input int d);
        logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return tbl[d];
    endfunction

    function automatic logic [6:0] exp_glyph(input int val, input int k, input bit lz);
        int m = (val < 0) ? -val : val;
        int p = 1;
        for (int j = 0; j < k; j++) p = p * 10;
        if (val < 0 && k == 3) return 7'h3F;
        if (lz && k > 0 && m < p) return 7'h7F;
        return glyph_of((m / p) % 10);
    endfunction

    bit         checking = 1'b0;
    int         m_busy_cnt, m_conv, m_disp, m_cnt, m_idx;
    bit         m_pend_v;
    logic [9:0] m_pend_val;
    bit         m_pend_sgn;
    logic [6:0] m_seg_a, m_seg_b;
    logic [3:0] m_an;

    task automatic m_start(input logic [9:0] v, input bit sgn);
        m_conv     = (sgn && v[9]) ? int'(v) - 1024 : int'(v);
        m_busy_cnt = 11;
    endtask

    task automatic model_step();
        if (reset) begin
            m_busy_cnt = 0; m_pend_v = 0; m_disp = 0; m_cnt = 0; m_idx = 0;
            m_seg_a = 7'h7F; m_seg_b = 7'h7F; m_an = 4'hF;
            checking = 1'b1;
        end else begin
            if (blank) begin
                m_seg_a = 7'h7F; m_seg_b = 7'h7F; m_an = 4'hF;
            end else begin
                m_seg_a = exp_glyph(m_disp, m_idx, 1'b1);
                m_seg_b = exp_glyph(m_disp, m_idx, 1'b0);
                m_an    = 4'hF & ~(4'd1 << m_idx);
            end
            if (m_cnt == DIV - 1) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % 4;
            end else begin
                m_cnt++;
            end
            if (m_busy_cnt == 0) begin
                if (value_valid) begin
                    m_start(value_in, signed_mode);
                    m_pend_v = 0;
                end else if (m_pend_v) begin
                    m_start(m_pend_val, m_pend_sgn);
                    m_pend_v = 0;
                end
            end else begin
                if (value_valid) begin
                    m_pend_v = 1; m_pend_val = value_in; m_pend_sgn = signed_mode;
                end
                m_busy_cnt--;
                if (m_busy_cnt == 0) m_disp = m_conv;
            end
        end
    endtask

    always @(posedge clock) begin
        model_step();
        #1;
        if (checking) begin
            check("busy_lz",   busy_a, m_busy_cnt != 0);
            check("busy_nolz", busy_b, m_busy_cnt != 0);
            check("seg_lz",    seg_a,  m_seg_a);
            check("seg_nolz",  seg_b,  m_seg_b);
            check("an_lz",     an_a,   m_an);
            check("an_nolz",   an_b,   m_an);
            check("dp_lz",     dp_a,   1'b1);
            check("dp_nolz",   dp_b,   1'b1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse(input logic [9:0] v, input bit sgn);
        value_in    = v;
        signed_mode = sgn;
        value_valid = 1'b1;
        @(negedge clock);
        value_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy_a && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (busy_a) check({name, "_idle_timeout"}, busy_a, 1'b0);
    endtask

    task automatic check_glyph(input bit use_b, input int k, input logic [6:0] exp,
                               input string name);
        logic [3:0] want = 4'hF;
        bit found = 0;
        want[k] = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clock);
            if ((use_b ? an_b : an_a) == want) begin
                found = 1;
                check(name, use_b ? seg_b : seg_a, exp);
            end
        end
        if (!found) check({name, "_scan_timeout"}, use_b ? an_b : an_a, want);
    endtask

    task automatic check_four(input bit use_b, input logic [6:0] d3, input logic [6:0] d2,
                              input logic [6:0] d1, input logic [6:0] d0, input string name);
        check_glyph(use_b, 3, d3, {name, "_d3"});
        check_glyph(use_b, 2, d2, {name, "_d2"});
        check_glyph(use_b, 1, d1, {name, "_d1"});
        check_glyph(use_b, 0, d0, {name, "_d0"});
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // 1: reset mid-conversion
        pulse(10'd300, 1'b0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("t1_busy", busy_a, 1'b0);
        check("t1_seg", seg_a, 7'h7F);
        check("t1_an", an_a, 4'hF);
        check_four(1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h40, "t1");

        // 2: full-scale unsigned, busy duration
        pulse(10'd1023, 1'b0);
        n = 1;
        while (busy_a && n < 60) begin
            @(negedge clock);
            if (busy_a) n++;
        end
        check("t2_busy_cycles", n, 11);
        check_four(1'b0, 7'h79, 7'h40, 7'h24, 7'h30, "t2");

        // 3: most negative signed value
        pulse(10'h200, 1'b1);
        wait_idle("t3");
        check_four(1'b0, 7'h3F, 7'h12, 7'h79, 7'h24, "t3");
        check_glyph(1'b1, 3, 7'h3F, "t3_nolz_d3");

        // 4: pending buffer, last writer wins
        pulse(10'd7, 1'b0);
        repeat (2) @(negedge clock);
        pulse(10'd45, 1'b0);
        @(negedge clock);
        pulse(10'd99, 1'b0);
        wait_idle("t4a");
        @(negedge clock);
        check("t4_restart_busy", busy_a, 1'b1);
        wait_idle("t4b");
        check_four(1'b0, 7'h7F, 7'h7F, 7'h10, 7'h10, "t4");
        check_four(1'b1, 7'h40, 7'h40, 7'h10, 7'h10, "t4_nolz");

        // 5: small value, with and without blanking
        pulse(10'd5, 1'b0);
        wait_idle("t5");
        check_four(1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h12, "t5");
        check_four(1'b1, 7'h40, 7'h40, 7'h40, 7'h12, "t5_nolz");

        // small negative, then same bits read unsigned (1019)
        pulse(10'h3FB, 1'b1);
        wait_idle("t5n");
        check_four(1'b0, 7'h3F, 7'h7F, 7'h7F, 7'h12, "t5n");
        check_four(1'b1, 7'h3F, 7'h40, 7'h40, 7'h12, "t5n_nolz");
        pulse(10'h3FB, 1'b0);
        wait_idle("t5u");
        check_four(1'b0, 7'h79, 7'h40, 7'h79, 7'h10, "t5u");

        // 6: blank during scan
        @(negedge clock);
        blank = 1'b1;
        @(negedge clock);
        check("t6_an_dark", an_a, 4'hF);
        check("t6_seg_dark", seg_a, 7'h7F);
        repeat (7) @(negedge clock);
        blank = 1'b0;
        repeat (20) @(negedge clock);
        check_four(1'b0, 7'h79, 7'h40, 7'h79, 7'h10, "t6");

        repeat (4) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

endmodule
